serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial add/subtract controller that shares a single `full_adder` cell across all bits of a WIDTH-bit operation. On a start request it latches both operands and the mode, then feeds the cell one bit pair per cycle, LSB first, through a registered carry. It reports the sum, carry-out and signed overflow with a one-cycle `done` pulse. It is the area-minimal alternative to a ripple chain of `full_adder` instances in the arithmetic datapath.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 1..32
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when not busy
- A  input  WIDTH  operand A; latched on an accepted start
- B  input  WIDTH  operand B; latched on an accepted start
- C0  input  1  carry-in for add mode; ignored when SUB=1; latched on an accepted start
- SUB  input  1  0 = A+B+C0; 1 = A-B, computed as A+~B+1; latched on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; S, C1 and OVF are valid from this cycle
- S  output  WIDTH  result
- C1  output  1  carry-out; in SUB mode 1 = no borrow (A >= B unsigned)
- OVF  output  1  two's-complement overflow

## Operation

- States: IDLE, RUN, DONE.
- IDLE: when start=1, latch A, B, SUB and the initial carry (C0 if SUB=0, 1 if SUB=1). Clear the bit counter and go to RUN.
- RUN: one bit per cycle.
  - The cell inputs are A_sh[0], B_sh[0] (inverted when SUB=1) and carry_q.
  - The sum bit shifts into the MSB of the result shift register. Both operand registers shift right. carry_q takes the cell's carry-out.
  - On the MSB step, capture the carry into the MSB (the cell's input carry_q) so OVF can be formed.
  - After WIDTH steps, go to DONE.
- DONE:
  - Copy the shift register to S.
  - Set C1 = final carry.
  - Set OVF = carry-into-MSB XOR carry-out-of-MSB.
  - Assert done.
  - Next state: if start=1, accept it exactly as in IDLE and go to RUN (back-to-back); otherwise go to IDLE.
- start while in RUN is ignored and has no queued effect.
- S, C1 and OVF change only on entry to DONE. They hold their last values through IDLE and through later RUN periods until the next completion.
- Input operands may change freely after the accepting edge.
- WIDTH=1: RUN lasts one cycle. OVF = C0 XOR carry-out in add mode, computed the same way as for other widths.

## Timing

- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - S = 0, C1 = 0, OVF = 0
  - internal carry_q, shift registers and bit counter = 0
- Reset takes priority over every other event, including start. Reset mid-RUN aborts the operation, and no done is produced.
- busy = 1 exactly in RUN. It is combinationally decodable from state and registered.
- done = 1 exactly in DONE.
- Latency: start accepted at edge k (k = 0 for a start in IDLE). Then:
  - busy is high for cycles k+1 .. k+WIDTH.
  - done is high in cycle k+WIDTH+1, with S/C1/OVF valid in that same cycle.
- Throughput with start held high: one result every WIDTH+1 cycles. busy drops for exactly the DONE cycle.
- Widths:
  - All arithmetic is modulo 2^WIDTH on S.
  - The carry is a single bit.
  - The bit counter is $clog2(WIDTH)+1 bits wide and must not wrap before reaching WIDTH.

## Test plan

- WIDTH=8, A=0x3C, B=0x15, C0=0, SUB=0, start pulse at edge 0 -> busy high in cycles 1–8; done in cycle 9 with S=0x51, C1=0, OVF=0.
- Add boundaries:
  - A=0xFF, B=0x01, C0=0 -> S=0x00, C1=1, OVF=0.
  - A=0x7F, B=0x01 -> S=0x80, C1=0, OVF=1.
  - A=0xFF, B=0xFF, C0=1 -> S=0xFF, C1=1, OVF=0.
- Subtract:
  - A=0x10, B=0x20, SUB=1 -> S=0xF0, C1=0, OVF=0.
  - A=0x80, B=0x01, SUB=1 -> S=0x7F, C1=1, OVF=1.
  - C0=1 is ignored in both cases.
- Start during RUN:
  - Issue a new start with different operands in cycle 4 of an operation -> the original result is unchanged, and exactly one done pulse occurs.
- start held high for two operations (0x01+0x02, then 0x03+0x04) -> done in cycles 9 and 18 with S=0x03 then S=0x07. S holds 0x03 during cycles 10–17.
- Reset:
  - Assert rst for 1 cycle in cycle 5 of RUN -> no done pulse; busy=0 and S/C1/OVF=0 from the next cycle.
  - A fresh start afterward completes correctly.
- Random regression against a reference model, at WIDTH=1, 8 and 32:
  - Random A, B, C0 and SUB, with start at random gaps.
  - Compare S, C1 and OVF on every done pulse.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract controller.
// The requester drives the master side, and the controller takes the slave side.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C0;
  logic             SUB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C1;
  logic             OVF;

  modport master (
    output start, A, B, C0, SUB,
    input  busy, done, S, C1, OVF
  );

  modport slave (
    input  start, A, B, C0, SUB,
    output busy, done, S, C1, OVF
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller. One full-adder cell is reused for every bit,
// least significant bit first, and the carry passes from step to step through a register.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, s_q;
  logic             carry_q, sub_q, c1_q, ovf_q;
  logic [CW-1:0]    cnt;

  logic             accept, last_step;
  logic             fa_a, fa_b, fa_sum, fa_cout;
  logic [WIDTH:0]   res_next;

  // The shared full-adder cell. In subtract mode, B is inverted here, and the +1 enters as the initial carry.
  always_comb begin
    fa_a      = a_sh[0];
    fa_b      = b_sh[0] ^ sub_q;
    fa_sum    = fa_a ^ fa_b ^ carry_q;
    fa_cout   = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
    res_next  = {fa_sum, res_sh};
    last_step = (cnt == CW'(WIDTH - 1));
    accept    = bus.start && (state != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default value first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Reset is synchronous and has priority over accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      c1_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= bus.A;
      b_sh    <= bus.B;
      sub_q   <= bus.SUB;
      carry_q <= bus.SUB ? 1'b1 : bus.C0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_next[WIDTH:1];
      carry_q <= fa_cout;
      cnt     <= cnt + CW'(1);
      // On the MSB step, carry_q is the carry into the MSB. The results are published on entry to DONE.
      if (last_step) begin
        s_q   <= res_next[WIDTH:1];
        c1_q  <= fa_cout;
        ovf_q <= carry_q ^ fa_cout;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.S    = s_q;
  assign bus.C1   = c1_q;
  assign bus.OVF  = ovf_q;
endmodule
